// File: rtl/stm_source_sel_pkg.sv
// stm_source_sel_pkg
//   Shared types for the STM / normal source selector.
//   state_t : sequencer state, 2-bit encoding visible on the STATE port.
//   sel_t   : which data source feeds the modulator.
//   source_of() maps a sequencer state onto the source it selects.
package stm_source_sel_pkg;

  localparam logic [1:0] ST_NORMAL_ENC      = 2'd0;
  localparam logic [1:0] ST_WAIT_START_ENC  = 2'd1;
  localparam logic [1:0] ST_STM_ENC         = 2'd2;
  localparam logic [1:0] ST_WAIT_FINISH_ENC = 2'd3;

  typedef enum logic [1:0] {
    NORMAL      = ST_NORMAL_ENC,
    WAIT_START  = ST_WAIT_START_ENC,
    STM         = ST_STM_ENC,
    WAIT_FINISH = ST_WAIT_FINISH_ENC
  } state_t;

  typedef enum logic {
    SEL_NORMAL = 1'b0,
    SEL_STM    = 1'b1
  } sel_t;

  // While waiting to finish, STM data must keep flowing until the exit point,
  // so WAIT_FINISH belongs to the STM side; WAIT_START stays on normal data.
  function automatic sel_t source_of(state_t s);
    return ((s == STM) || (s == WAIT_FINISH)) ? SEL_STM : SEL_NORMAL;
  endfunction

endpackage

// File: rtl/stm_source_sel_wait_timer.sv
// wait_timer
//   Cycle counter for the selector's wait states. Counts cycles while EN is
//   high and asserts EXPIRE combinationally in the cycle where the count has
//   reached LIMIT-1, so the caller can leave the wait on that same edge.
//   A LIMIT of 0 disables expiry.
// Ports:
//   CLK     : clock (posedge)
//   RESET_N : asynchronous active-low reset
//   CLR     : synchronous clear of the count (has priority over EN)
//   EN      : count enable
//   LIMIT   : wait limit in cycles, 0 = no limit
//   EXPIRE  : limit reached this cycle
module wait_timer #(
  parameter int TO_W = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            CLR,
  input  logic            EN,
  input  logic [TO_W-1:0] LIMIT,
  output logic            EXPIRE
);

  logic [TO_W-1:0] count;

  // The count sits at zero whenever the owner is not waiting, so it is
  // already cleared on the edge that enters a wait state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (EN) begin
      count <= count + TO_W'(1);
    end
  end

  assign EXPIRE = EN && (LIMIT != '0) && (count == (LIMIT - TO_W'(1)));

endmodule

// File: rtl/stm_source_sel.sv
// stm_source_sel
//   Chooses, per transducer, between normal-mode and STM-mode duty/phase in
//   front of the modulator. Entry to and exit from STM can be gated on a
//   specific STM index; an index outside the STM cycle bypasses the gate.
//   Optional feature macro: STM_SOURCE_SEL_TIMEOUT_EN adds a wait-state
//   timeout (TIMEOUT_CYCLES, TIMEOUT pulse). Without it TIMEOUT is tied 0
//   and waits end only by abort or index match.
// Ports:
//   CLK, RESET_N                  : clock, asynchronous active-low reset
//   OP_MODE                       : 1 requests STM, 0 requests normal
//   USE_START_IDX / START_IDX     : gate STM entry on this index
//   USE_FINISH_IDX / FINISH_IDX   : gate STM exit on this index
//   STM_CYCLE                     : number of STM points (range check)
//   STM_DONE / STM_IDX            : STM index advance pulse and index
//   TIMEOUT_CYCLES                : wait limit, 0 = unlimited
//   DUTY/PHASE_NORMAL, DUTY/PHASE_STM : the two data sources
//   DUTY, PHASE                   : selected data, registered
//   STM_ACTIVE, STATE             : selected source and sequencer state
//   SWITCH, TIMEOUT               : source-change and forced-exit pulses
module stm_source_sel
  import stm_source_sel_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249,
  parameter int IDX_W = 16,
  parameter int TO_W  = 32
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        OP_MODE,
  input  logic                        USE_START_IDX,
  input  logic [IDX_W-1:0]            START_IDX,
  input  logic                        USE_FINISH_IDX,
  input  logic [IDX_W-1:0]            FINISH_IDX,
  input  logic [IDX_W-1:0]            STM_CYCLE,
  input  logic                        STM_DONE,
  input  logic [IDX_W-1:0]            STM_IDX,
  input  logic [TO_W-1:0]             TIMEOUT_CYCLES,
  input  logic [DEPTH-1:0][WIDTH-1:0] DUTY_NORMAL,
  input  logic [DEPTH-1:0][WIDTH-1:0] PHASE_NORMAL,
  input  logic [DEPTH-1:0][WIDTH-1:0] DUTY_STM,
  input  logic [DEPTH-1:0][WIDTH-1:0] PHASE_STM,
  output logic [DEPTH-1:0][WIDTH-1:0] DUTY,
  output logic [DEPTH-1:0][WIDTH-1:0] PHASE,
  output logic                        STM_ACTIVE,
  output logic [1:0]                  STATE,
  output logic                        SWITCH,
  output logic                        TIMEOUT
);

  state_t state;
  sel_t   sel_next;
  sel_t   sel_q;
  logic   timeout_q;
  logic   start_valid;
  logic   finish_valid;
  logic   start_hit;
  logic   finish_hit;
  logic   expire;

  // An index outside the STM cycle can never be reached, so it is treated
  // as if gating were switched off. Configuration is sampled live.
  assign start_valid  = USE_START_IDX  && (START_IDX  < STM_CYCLE);
  assign finish_valid = USE_FINISH_IDX && (FINISH_IDX < STM_CYCLE);
  assign start_hit    = STM_DONE && (STM_IDX == START_IDX);
  assign finish_hit   = STM_DONE && (STM_IDX == FINISH_IDX);

`ifdef STM_SOURCE_SEL_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state == WAIT_START) || (state == WAIT_FINISH);

  wait_timer #(
    .TO_W(TO_W)
  ) u_wait_timer (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .CLR(!in_wait),
    .EN(in_wait),
    .LIMIT(TIMEOUT_CYCLES),
    .EXPIRE(expire)
  );

  assign TIMEOUT = timeout_q;
`else
  logic unused_timeout;
  assign expire         = 1'b0;
  assign TIMEOUT        = 1'b0;
  assign unused_timeout = ^{TIMEOUT_CYCLES, timeout_q};
`endif

  // Sequencer. Within a wait state an OP_MODE abort beats an index match,
  // which beats the timeout. Aborts return to the side we came from, so no
  // source change (and no SWITCH) results from them.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= NORMAL;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        NORMAL: begin
          if (OP_MODE) state <= start_valid ? WAIT_START : STM;
        end
        WAIT_START: begin
          if (!OP_MODE) begin
            state <= NORMAL;
          end else if (start_hit) begin
            state <= STM;
          end else if (expire) begin
            state     <= STM;
            timeout_q <= 1'b1;
          end
        end
        STM: begin
          if (!OP_MODE) state <= finish_valid ? WAIT_FINISH : NORMAL;
        end
        WAIT_FINISH: begin
          if (OP_MODE) begin
            state <= STM;
          end else if (finish_hit) begin
            state <= NORMAL;
          end else if (expire) begin
            state     <= NORMAL;
            timeout_q <= 1'b1;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  assign sel_next = source_of(state);

  // Output stage: one register after the state, so the data switch and the
  // SWITCH pulse land one edge after the state transition.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sel_q  <= SEL_NORMAL;
      SWITCH <= 1'b0;
      DUTY   <= '0;
      PHASE  <= '0;
    end else begin
      sel_q  <= sel_next;
      SWITCH <= (sel_next != sel_q);
      if (sel_next == SEL_STM) begin
        DUTY  <= DUTY_STM;
        PHASE <= PHASE_STM;
      end else begin
        DUTY  <= DUTY_NORMAL;
        PHASE <= PHASE_NORMAL;
      end
    end
  end

  assign STM_ACTIVE = (sel_q == SEL_STM);
  assign STATE      = state;

endmodule

// File: tb/tb_stm_source_sel.sv
// tb_stm_source_sel
//   Self-checking bench for stm_source_sel: directed scenarios with literal
//   expectations, then randomized traffic checked every cycle against a
//   behavioural model (side + waiting flags, cycles-waited count).
//   Honours STM_SOURCE_SEL_TIMEOUT_EN the same way the design does.
module tb_stm_source_sel;

  localparam int WIDTH = 13;
  localparam int DEPTH = 8;
  localparam int IDX_W = 4;
  localparam int TO_W  = 8;

`ifdef STM_SOURCE_SEL_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef logic [DEPTH-1:0][WIDTH-1:0] vec_t;

  logic             clk;
  logic             rst_n;
  logic             op_mode;
  logic             use_start;
  logic [IDX_W-1:0] start_idx;
  logic             use_finish;
  logic [IDX_W-1:0] finish_idx;
  logic [IDX_W-1:0] stm_cycle;
  logic             stm_done;
  logic [IDX_W-1:0] stm_idx;
  logic [TO_W-1:0]  timeout_cycles;
  vec_t             duty_n, phase_n, duty_s, phase_s;
  vec_t             duty, phase;
  logic             stm_active;
  logic [1:0]       state;
  logic             switch_p;
  logic             timeout_p;

  int checks = 0;
  int errors = 0;

  stm_source_sel #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .TO_W(TO_W)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .OP_MODE(op_mode),
    .USE_START_IDX(use_start),
    .START_IDX(start_idx),
    .USE_FINISH_IDX(use_finish),
    .FINISH_IDX(finish_idx),
    .STM_CYCLE(stm_cycle),
    .STM_DONE(stm_done),
    .STM_IDX(stm_idx),
    .TIMEOUT_CYCLES(timeout_cycles),
    .DUTY_NORMAL(duty_n),
    .PHASE_NORMAL(phase_n),
    .DUTY_STM(duty_s),
    .PHASE_STM(phase_s),
    .DUTY(duty),
    .PHASE(phase),
    .STM_ACTIVE(stm_active),
    .STATE(state),
    .SWITCH(switch_p),
    .TIMEOUT(timeout_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t pattern(input int base);
    vec_t v;
    for (int i = 0; i < DEPTH; i++) v[i] = WIDTH'(base + i);
    return v;
  endfunction

  function automatic vec_t random_vec();
    vec_t v;
    for (int i = 0; i < DEPTH; i++) v[i] = WIDTH'($urandom);
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Behavioural model: m_stm says which side (STM or normal) we are on,
  // m_wait says a gated change is pending. STATE = {side, waiting}.
  bit   m_stm = 1'b0;
  bit   m_wait = 1'b0;
  int   m_waited = 0;
  bit   e_active = 1'b0;
  bit   e_switch = 1'b0;
  bit   e_timeout = 1'b0;
  vec_t e_duty = '0;
  vec_t e_phase = '0;

  always @(posedge clk) begin
    bit          gate_ok;
    logic [IDX_W-1:0] target;
    if (!rst_n) begin
      m_stm = 1'b0; m_wait = 1'b0; m_waited = 0;
      e_active = 1'b0; e_switch = 1'b0; e_timeout = 1'b0;
      e_duty = '0; e_phase = '0;
    end else begin
      // Outputs registered from the side held before this edge.
      e_switch  = (m_stm != e_active);
      e_active  = m_stm;
      e_duty    = m_stm ? duty_s : duty_n;
      e_phase   = m_stm ? phase_s : phase_n;
      e_timeout = 1'b0;
      if (!m_wait) begin
        if (op_mode != m_stm) begin
          gate_ok = op_mode ? (use_start && (start_idx < stm_cycle))
                            : (use_finish && (finish_idx < stm_cycle));
          if (gate_ok) begin
            m_wait = 1'b1;
            m_waited = 0;
          end else begin
            m_stm = op_mode;
          end
        end
      end else begin
        target = m_stm ? finish_idx : start_idx;
        if (op_mode == m_stm) begin
          m_wait = 1'b0;
        end else if (stm_done && (stm_idx == target)) begin
          m_stm = !m_stm;
          m_wait = 1'b0;
        end else if (TIMEOUT_ON && (timeout_cycles != 0) &&
                     (m_waited + 1 == int'(timeout_cycles))) begin
          m_stm = !m_stm;
          m_wait = 1'b0;
          e_timeout = 1'b1;
        end else begin
          m_waited++;
        end
      end
    end
    #1;
    checkOutput("model_state",   128'(state),      128'({m_stm, m_wait}));
    checkOutput("model_active",  128'(stm_active), 128'(e_active));
    checkOutput("model_switch",  128'(switch_p),   128'(e_switch));
    checkOutput("model_timeout", 128'(timeout_p),  128'(e_timeout));
    checkOutput("model_duty",    128'(duty),       128'(e_duty));
    checkOutput("model_phase",   128'(phase),      128'(e_phase));
  end

  task automatic applyStimulus(input int cyc);
    if (cyc % 200 == 0) timeout_cycles = TO_W'($urandom_range(0, 6));
    if ($urandom_range(0, 7) == 0) op_mode = !op_mode;
    use_start  = 1'($urandom_range(0, 1));
    use_finish = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) begin
      start_idx  = IDX_W'($urandom_range(0, 15));
      finish_idx = IDX_W'($urandom_range(0, 15));
      stm_cycle  = IDX_W'($urandom_range(0, 15));
    end
    stm_done = ($urandom_range(0, 2) == 0);
    stm_idx  = IDX_W'($urandom_range(0, 15));
    duty_n   = random_vec();
    phase_n  = random_vec();
    duty_s   = random_vec();
    phase_s  = random_vec();
  endtask

  initial begin
    rst_n = 1'b0;
    op_mode = 1'b0; use_start = 1'b0; start_idx = '0;
    use_finish = 1'b0; finish_idx = '0; stm_cycle = '0;
    stm_done = 1'b0; stm_idx = '0; timeout_cycles = '0;
    duty_n  = pattern(13'h100);
    phase_n = pattern(13'h200);
    duty_s  = pattern(13'h300);
    phase_s = pattern(13'h400);

    repeat (3) step();
    checkOutput("reset_state", 128'(state), 128'(0));
    checkOutput("reset_duty",  128'(duty),  128'(0));
    checkOutput("reset_active", 128'(stm_active), 128'(0));
    rst_n = 1'b1;
    repeat (2) step();

    // Ungated entry: state changes on the sampling edge, data one edge later
    $display("[TB] ungated entry");
    op_mode = 1'b1;
    step();
    checkOutput("ungated_state", 128'(state), 128'(2));
    checkOutput("ungated_active_early", 128'(stm_active), 128'(0));
    step();
    checkOutput("ungated_active", 128'(stm_active), 128'(1));
    checkOutput("ungated_switch", 128'(switch_p), 128'(1));
    checkOutput("ungated_duty", 128'(duty), 128'(pattern(13'h300)));
    step();
    checkOutput("ungated_switch_end", 128'(switch_p), 128'(0));

    // Gated exit with an abort in the middle
    $display("[TB] gated exit");
    use_finish = 1'b1; finish_idx = 4'd2; stm_cycle = 4'd10; op_mode = 1'b0;
    step();
    checkOutput("exit_wait_state", 128'(state), 128'(3));
    stm_done = 1'b1; stm_idx = 4'd0;
    step();
    checkOutput("exit_nomatch_state", 128'(state), 128'(3));
    checkOutput("exit_stm_flowing", 128'(duty), 128'(pattern(13'h300)));
    stm_done = 1'b0; op_mode = 1'b1;
    step();
    checkOutput("exit_abort_state", 128'(state), 128'(2));
    step();
    checkOutput("exit_abort_noswitch", 128'(switch_p), 128'(0));
    checkOutput("exit_abort_active", 128'(stm_active), 128'(1));
    op_mode = 1'b0;
    step();
    checkOutput("exit_rewait_state", 128'(state), 128'(3));
    stm_done = 1'b1; stm_idx = 4'd2;
    step();
    checkOutput("exit_match_state", 128'(state), 128'(0));
    stm_done = 1'b0;
    step();
    checkOutput("exit_active", 128'(stm_active), 128'(0));
    checkOutput("exit_switch", 128'(switch_p), 128'(1));
    checkOutput("exit_duty", 128'(duty), 128'(pattern(13'h100)));

    // Gated entry on index 5
    $display("[TB] gated entry");
    use_start = 1'b1; start_idx = 4'd5; op_mode = 1'b1;
    step();
    checkOutput("entry_wait_state", 128'(state), 128'(1));
    for (int i = 3; i <= 5; i++) begin
      stm_done = 1'b1; stm_idx = IDX_W'(i);
      step();
      checkOutput("entry_idx_state", 128'(state), 128'((i == 5) ? 2 : 1));
    end
    stm_done = 1'b0;
    step();
    checkOutput("entry_switch", 128'(switch_p), 128'(1));
    checkOutput("entry_duty", 128'(duty), 128'(pattern(13'h300)));

    // Out-of-range start index bypasses the gate
    $display("[TB] out-of-range bypass");
    op_mode = 1'b0; use_finish = 1'b0;
    step();
    checkOutput("oor_back_normal", 128'(state), 128'(0));
    step();
    start_idx = 4'd12; op_mode = 1'b1;
    step();
    checkOutput("oor_direct_stm", 128'(state), 128'(2));

    // Timeout in WAIT_START: four cycles waiting, then forced into STM
    $display("[TB] timeout");
    op_mode = 1'b0;
    step();
    start_idx = 4'd5; timeout_cycles = 8'd4; op_mode = 1'b1;
    step();
    checkOutput("to_wait_state", 128'(state), 128'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("to_still_wait", 128'(state), 128'(1));
      checkOutput("to_no_pulse", 128'(timeout_p), 128'(0));
    end
    step();
    checkOutput("to_expire_state", 128'(state), 128'(TIMEOUT_ON ? 2 : 1));
    checkOutput("to_expire_pulse", 128'(timeout_p), 128'(TIMEOUT_ON ? 1 : 0));
    repeat (5) step();
    checkOutput("to_after_state", 128'(state), 128'(TIMEOUT_ON ? 2 : 1));

    // Reset while in WAIT_FINISH
    $display("[TB] reset mid-wait");
    op_mode = 1'b0; use_finish = 1'b0; timeout_cycles = '0;
    repeat (2) step();
    use_start = 1'b0; op_mode = 1'b1;
    repeat (2) step();
    use_finish = 1'b1; finish_idx = 4'd2; stm_cycle = 4'd10; op_mode = 1'b0;
    step();
    checkOutput("rst_pre_state", 128'(state), 128'(3));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_state", 128'(state), 128'(0));
    checkOutput("rst_async_active", 128'(stm_active), 128'(0));
    checkOutput("rst_async_duty", 128'(duty), 128'(0));
    checkOutput("rst_async_phase", 128'(phase), 128'(0));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    checkOutput("rst_release_state", 128'(state), 128'(0));

    // Randomized traffic against the model
    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(cyc);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
